// File: rtl/int_to_rec_fn_pkg.sv
// Shared constants and helpers for the integer-to-recoded-float converter.
package int_to_rec_fn_pkg;

    localparam logic [2:0] RM_NEAR_EVEN   = 3'd0;
    localparam logic [2:0] RM_MIN_MAG     = 3'd1;
    localparam logic [2:0] RM_MIN         = 3'd2;
    localparam logic [2:0] RM_MAX         = 3'd3;
    localparam logic [2:0] RM_NEAR_MAXMAG = 3'd4;

    localparam int FLAG_INVALID   = 4;
    localparam int FLAG_INFINITE  = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    // Top three recoded exponent bits that mark a zero value.
    localparam logic [2:0] REC_ZERO_EXP = 3'b000;

    function automatic int rec_w(input int exp_w, input int sig_w);
        return exp_w + sig_w + 1;
    endfunction

endpackage

// File: rtl/int_to_rec_fn_pipe_lzc_pri.sv
// Priority leading-zero counter; an all-zero vector reports W.
module lzc_pri #(
    parameter int W  = 64,
    parameter int CW = $clog2(W) + 1
) (
    input  logic [W-1:0]  vec,
    output logic [CW-1:0] cnt
);

    // Ascending scan so the highest set bit is the last writer.
    always_comb begin
        cnt = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (vec[i]) cnt = CW'(W - 1 - i);
        end
    end

endmodule

// File: rtl/int_to_rec_fn_pipe.sv
// Three-stage integer to recoded-float converter with valid/ready flow control.
module int_to_rec_fn_pipe
    import int_to_rec_fn_pkg::*;
#(
    parameter int IN_W  = 64,
    parameter int EXP_W = 8,
    parameter int SIG_W = 24
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            in_signed,
    input  logic [IN_W-1:0]                 in_data,
    input  logic [2:0]                      in_rm,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [rec_w(EXP_W, SIG_W)-1:0]  out_data,
    output logic [4:0]                      out_flags
);

    localparam int CW = $clog2(IN_W) + 1;
    localparam int RW = EXP_W + 1;
    localparam int OW = rec_w(EXP_W, SIG_W);
    localparam logic [RW-1:0] EXP_BIAS = RW'(1) << EXP_W;
    localparam logic [RW-1:0] EXP_TOP  = RW'(IN_W - 1);

    logic [2:0] vld_pipe;
    logic [2:0] adv;

    assign adv[2]    = !vld_pipe[2] | out_ready;
    assign adv[1]    = !vld_pipe[1] | adv[2];
    assign adv[0]    = !vld_pipe[0] | adv[1];
    assign in_ready  = adv[0];
    assign out_valid = vld_pipe[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else begin
            if (adv[0]) vld_pipe[0] <= in_valid;
            if (adv[1]) vld_pipe[1] <= vld_pipe[0];
            if (adv[2]) vld_pipe[2] <= vld_pipe[1];
        end
    end

    // S1: sign and magnitude; the most negative value wraps to 2^(IN_W-1).
    logic            in_neg;
    logic            s1_sign;
    logic [IN_W-1:0] s1_mag;
    logic [2:0]      s1_rm;

    assign in_neg = in_signed & in_data[IN_W-1];

    always_ff @(posedge clk) begin
        if (adv[0] && in_valid) begin
            s1_sign <= in_neg;
            s1_mag  <= in_neg ? ('0 - in_data) : in_data;
            s1_rm   <= in_rm;
        end
    end

    // S2: normalise so the leading one sits at the MSB.
    logic [CW-1:0]   lz;
    logic            s2_sign;
    logic            s2_zero;
    logic [IN_W-1:0] s2_norm;
    logic [CW-1:0]   s2_lzc;
    logic [2:0]      s2_rm;

    lzc_pri #(.W(IN_W), .CW(CW)) u_lzc (
        .vec (s1_mag),
        .cnt (lz)
    );

    always_ff @(posedge clk) begin
        if (adv[1] && vld_pipe[0]) begin
            s2_sign <= s1_sign;
            s2_zero <= (s1_mag == '0);
            s2_norm <= s1_mag << lz;
            s2_lzc  <= lz;
            s2_rm   <= s1_rm;
        end
    end

    // S3: round, build exponent, recode into the output register.
    logic [SIG_W-1:0] kept;
    logic             rnd;
    logic             sticky;
    logic             inc;
    logic [SIG_W:0]   sum;
    logic [RW-1:0]    exp_val;
    logic [OW-1:0]    res;
    logic [4:0]       flg;

    assign kept   = s2_norm[IN_W-1 -: SIG_W];
    assign rnd    = s2_norm[IN_W-1-SIG_W];
    assign sticky = |(s2_norm << (SIG_W + 1));

    always_comb begin
        inc = 1'b0;
        case (s2_rm)
            RM_MIN_MAG:     inc = 1'b0;
            RM_MIN:         inc = s2_sign & (rnd | sticky);
            RM_MAX:         inc = !s2_sign & (rnd | sticky);
            RM_NEAR_MAXMAG: inc = rnd;
            default:        inc = rnd & (sticky | kept[0]);
        endcase
    end

    // A carry out leaves the fraction field at zero, so only the exponent moves.
    assign sum     = {1'b0, kept} + (SIG_W+1)'(inc);
    assign exp_val = EXP_BIAS + EXP_TOP - RW'(s2_lzc) + RW'(sum[SIG_W]);

    always_comb begin
        res = {s2_sign, exp_val, sum[SIG_W-2:0]};
        flg = '0;
        flg[FLAG_INVALID]   = 1'b0;
        flg[FLAG_INFINITE]  = 1'b0;
        flg[FLAG_OVERFLOW]  = 1'b0;
        flg[FLAG_UNDERFLOW] = 1'b0;
        flg[FLAG_INEXACT]   = rnd | sticky;
        if (s2_zero) begin
            res = {1'b0, REC_ZERO_EXP, {(RW-3){1'b0}}, {(SIG_W-1){1'b0}}};
            flg = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_flags <= '0;
        end else if (adv[2] && vld_pipe[1]) begin
            out_data  <= res;
            out_flags <= flg;
        end
    end

endmodule

// File: tb/tb_int_to_rec_fn_pipe.sv
// Randomised and directed bench for int_to_rec_fn_pipe against an arithmetic model.
module tb_int_to_rec_fn_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_signed = 1'b0;
    logic [63:0] in_data = '0;
    logic [2:0]  in_rm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [32:0] out_data;
    logic [4:0]  out_flags;

    int checks = 0;
    int failures = 0;
    logic [37:0] exp_q[$];

    int_to_rec_fn_pipe #(.IN_W(64), .EXP_W(8), .SIG_W(24)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_signed (in_signed),
        .in_data   (in_data),
        .in_rm     (in_rm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flags (out_flags)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Reference: round the magnitude to 24 significant bits by comparing the
    // discarded remainder with one half ulp; returns {flags, recoded value}.
    function automatic logic [37:0] model(input logic s, input logic [63:0] d, input logic [2:0] rm);
        logic        neg, inc;
        logic [63:0] mag, kept, rem, half;
        int          p, sh;
        logic [8:0]  e;
        neg = s & d[63];
        mag = neg ? (64'(0) - d) : d;
        if (mag == 0) return '0;
        p = 0;
        for (int i = 0; i < 64; i++) if (mag[i]) p = i;
        rem = 0;
        half = 0;
        if (p <= 23) kept = mag << (23 - p);
        else begin
            sh = p - 23;
            kept = mag >> sh;
            rem = mag - (kept << sh);
            half = 64'd1 << (sh - 1);
        end
        case (rm)
            3'd1:    inc = 1'b0;
            3'd2:    inc = neg && rem != 0;
            3'd3:    inc = !neg && rem != 0;
            3'd4:    inc = rem != 0 && rem >= half;
            default: inc = rem != 0 && (rem > half || (rem == half && kept[0]));
        endcase
        kept = kept + 64'(inc);
        if (kept == (64'd1 << 24)) begin
            kept = kept >> 1;
            p++;
        end
        e = 9'(256 + p);
        return {4'b0, rem != 0, neg, e, kept[22:0]};
    endfunction

    function automatic logic [63:0] rand_data();
        logic [63:0] d;
        d = {$urandom, $urandom};
        case ($urandom_range(0, 4))
            0: return d;
            1: return d >> $urandom_range(0, 63);
            2: return 64'(0) - (d >> $urandom_range(30, 63));
            3: return 64'($urandom_range(0, 3)) << $urandom_range(0, 63);
            default: return (64'd1 << $urandom_range(24, 63)) + 64'($urandom_range(0, 2));
        endcase
    endfunction

    task automatic tick(input logic v, input logic s, input logic [63:0] d,
                        input logic [2:0] rm, input logic ordy);
        @(negedge clk);
        in_valid = v; in_signed = s; in_data = d; in_rm = rm; out_ready = ordy;
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid_low got=%b exp=0", out_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++;
        if (out_data !== 33'h0 || out_flags !== 5'h0) begin
            failures++; $display("FAIL reset_out_zero got=%h/%h exp=0/0", out_data, out_flags);
        end
    endtask

    task automatic test_directed();
        logic        ts   [13] = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1};
        logic [63:0] td   [13] = '{64'd1, '1, 64'd0, 64'h1000001, 64'h1000001, 64'h1000001,
                                   64'h1000001, '1, '1, 64'h8000000000000000, 64'h1000003,
                                   64'hFFFFFFFFFEFFFFFF, 64'hFFFFFFFFFEFFFFFF};
        logic [2:0]  trm  [13] = '{0, 0, 0, 0, 3, 4, 7, 0, 1, 0, 0, 2, 3};
        logic [32:0] tout [13] = '{33'h080000000, 33'h180000000, 33'h0, 33'h08C000000, 33'h08C000001,
                                   33'h08C000001, 33'h08C000000, 33'h0A0000000, 33'h09FFFFFFF,
                                   33'h19F800000, 33'h08C000002, 33'h18C000001, 33'h18C000000};
        logic        tinx [13] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 0, 1, 1, 1};
        for (int k = 0; k < 13; k++) begin
            tick(1'b1, ts[k], td[k], trm[k], 1'b1);
            checks++;
            if (in_ready !== 1'b1) begin failures++; $display("FAIL dir%0d_in_ready got=%b exp=1", k, in_ready); end
            for (int c = 1; c <= 3; c++) begin
                tick(1'b0, 1'b0, '0, '0, 1'b1);
                checks++;
                if (out_valid !== (c == 3)) begin
                    failures++; $display("FAIL dir%0d_latency cycle=%0d got=%b exp=%b", k, c, out_valid, c == 3);
                end
            end
            checks++;
            if (out_data !== tout[k] || out_flags !== {4'b0, tinx[k]}) begin
                failures++;
                $display("FAIL dir%0d_result got=%h/%h exp=%h/%h", k, out_data, out_flags, tout[k], {4'b0, tinx[k]});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic        rs[6];
        logic [63:0] rd[6];
        logic [2:0]  rr[6];
        logic [37:0] e;
        logic [32:0] held;
        int issued = 0, got = 0;
        exp_q.delete();
        for (int k = 0; k < 6; k++) begin
            rs[k] = 1'($urandom); rd[k] = rand_data(); rr[k] = 3'($urandom_range(0, 7));
        end
        held = '0;
        for (int c = 1; c <= 5; c++) begin
            tick(1'b1, rs[issued], rd[issued], rr[issued], 1'b0);
            if (c >= 4) begin
                checks++;
                if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_stall_in_ready cycle=%0d got=%b exp=0", c, in_ready); end
                checks++;
                if (out_valid !== 1'b1 || out_data !== exp_q[0][32:0]) begin
                    failures++; $display("FAIL b2b_held_head cycle=%0d got=%b/%h exp=1/%h", c, out_valid, out_data, exp_q[0][32:0]);
                end
                if (c == 5) begin
                    checks++;
                    if (out_data !== held) begin failures++; $display("FAIL b2b_stable got=%h exp=%h", out_data, held); end
                end
                held = out_data;
            end
            if (in_ready) begin
                exp_q.push_back(model(rs[issued], rd[issued], rr[issued]));
                issued++;
            end
        end
        checks++;
        if (issued !== 3) begin failures++; $display("FAIL b2b_accepted got=%0d exp=3", issued); end
        for (int c = 0; c < 40 && got < 6; c++) begin
            if (issued < 6) tick(1'b1, rs[issued], rd[issued], rr[issued], 1'b1);
            else tick(1'b0, 1'b0, '0, '0, 1'b1);
            if (issued < 6 && in_ready) begin
                exp_q.push_back(model(rs[issued], rd[issued], rr[issued]));
                issued++;
            end
            if (out_valid) begin
                e = exp_q.pop_front();
                got++;
                checks++;
                if (out_data !== e[32:0] || out_flags !== e[37:33]) begin
                    failures++; $display("FAIL b2b_order%0d got=%h/%h exp=%h/%h", got, out_data, out_flags, e[32:0], e[37:33]);
                end
            end
        end
        checks++;
        if (got !== 6) begin failures++; $display("FAIL b2b_delivered got=%0d exp=6", got); end
    endtask

    task automatic test_random();
        logic        v, s, ordy, prev_stall;
        logic [63:0] d;
        logic [2:0]  rm;
        logic [32:0] prev_d;
        logic [4:0]  prev_f;
        logic [37:0] e;
        exp_q.delete();
        prev_stall = 1'b0; prev_d = '0; prev_f = '0;
        for (int c = 0; c < 500; c++) begin
            v = ($urandom_range(0, 3) != 0);
            s = 1'($urandom);
            d = rand_data();
            rm = 3'($urandom_range(0, 7));
            ordy = ($urandom_range(0, 2) != 0);
            tick(v, s, d, rm, ordy);
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== prev_d || out_flags !== prev_f) begin
                    failures++; $display("FAIL rand_stable got=%b/%h exp=1/%h", out_valid, out_data, prev_d);
                end
            end
            if (v && in_ready) exp_q.push_back(model(s, d, rm));
            if (out_valid && ordy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL rand_extra got=%h exp=none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e[32:0] || out_flags !== e[37:33]) begin
                        failures++; $display("FAIL rand_result got=%h/%h exp=%h/%h", out_data, out_flags, e[32:0], e[37:33]);
                    end
                end
            end
            prev_stall = out_valid && !ordy;
            prev_d = out_data;
            prev_f = out_flags;
        end
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
            tick(1'b0, 1'b0, '0, '0, 1'b1);
            if (out_valid) begin
                e = exp_q.pop_front();
                checks++;
                if (out_data !== e[32:0] || out_flags !== e[37:33]) begin
                    failures++; $display("FAIL rand_drain got=%h/%h exp=%h/%h", out_data, out_flags, e[32:0], e[37:33]);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL rand_lost got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] d;
        logic [37:0] e;
        int stale = 0, acc = 0;
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, 1'b0, rand_data(), 3'd0, 1'b0);
            if (in_ready) acc++;
        end
        checks++;
        if (acc !== 3) begin failures++; $display("FAIL rmid_accepted got=%0d exp=3", acc); end
        tick(1'b0, 1'b0, '0, '0, 1'b0);
        checks++;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL rmid_in_flight got=%b exp=1", out_valid); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 33'h0) begin
            failures++; $display("FAIL rmid_async_clear got=%b/%h exp=0/0", out_valid, out_data);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick(1'b0, 1'b0, '0, '0, 1'b1);
            if (out_valid) stale++;
        end
        checks++;
        if (stale !== 0) begin failures++; $display("FAIL rmid_stale got=%0d exp=0", stale); end
        d = rand_data();
        e = model(1'b1, d, 3'd2);
        tick(1'b1, 1'b1, d, 3'd2, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            tick(1'b0, 1'b0, '0, '0, 1'b1);
            checks++;
            if (out_valid !== (c == 3)) begin
                failures++; $display("FAIL rmid_latency cycle=%0d got=%b exp=%b", c, out_valid, c == 3);
            end
        end
        checks++;
        if (out_data !== e[32:0] || out_flags !== e[37:33]) begin
            failures++; $display("FAIL rmid_result got=%h/%h exp=%h/%h", out_data, out_flags, e[32:0], e[37:33]);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/int_to_rec_fn_pipe.md
INT_TO_REC_FN_PIPE -- requirements
Module: int_to_rec_fn_pipe

Interface
REQ-001 Parameter IN_W, default 64, integer input width; legal 8..64.
REQ-002 Parameter EXP_W, default 8, IEEE exponent width; legal 8 or 11; IN_W <= 2^(EXP_W-1) required.
REQ-003 Parameter SIG_W, default 24, significand width including hidden bit; legal 24 or 53; SIG_W < IN_W required.
REQ-004 clk  input  1  sole clock; all flops rising-edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  request present.
REQ-007 in_ready  output  1  block accepts request this cycle.
REQ-008 in_signed  input  1  1 = in_data is two's complement, 0 = unsigned.
REQ-009 in_data  input  IN_W  integer operand.
REQ-010 in_rm  input  3  rounding mode: 0 near_even, 1 minMag, 2 min, 3 max, 4 near_maxMag; 5-7 behave as near_even.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 out_data  output  EXP_W+SIG_W+1  recoded float {sign, EXP_W+1-bit exponent, SIG_W-1 fraction}.
REQ-014 out_flags  output  5  {invalid, infinite, overflow, underflow, inexact}; bits 4:1 SHALL be constant 0.

Function
REQ-015 Transfer on in_valid&in_ready; result transfer on out_valid&out_ready; in_signed, in_data, in_rm captured together.
REQ-016 Three-stage pipeline: S1 sign and magnitude (sign = in_signed & msb; magnitude negated when sign); S2 leading-zero count and left-normalise; S3 round, exponent, recode.
REQ-017 Latency exactly 3 cycles from accept to out_valid when unstalled; throughput 1 per cycle.
REQ-018 Each stage holds a valid bit; a stage advances when empty or its successor advances; in_ready = !S1_valid | S1 advances (no combinational path in_valid -> in_ready).
REQ-019 out_valid, out_data, out_flags SHALL be stable while out_valid & !out_ready.
REQ-020 Results emerge in acceptance order; no drop, no duplication under any out_ready pattern.
REQ-021 Kept significand = top SIG_W bits of normalised magnitude; round bit = next bit; sticky = OR of all lower bits.
REQ-022 Increment when: near_even round&(sticky|lsb); minMag never; min sign&(round|sticky); max !sign&(round|sticky); near_maxMag round.
REQ-023 Significand carry-out SHALL renormalise to fraction 0 and add 1 to exponent.
REQ-024 Nonzero exponent = 2^EXP_W + (IN_W-1-lzc) + carry; zero input yields exponent 0, fraction 0, sign 0, flags 0.
REQ-025 inexact = round | sticky; never overflow (guaranteed by REQ-002).
REQ-026 Most-negative signed input SHALL convert exactly as magnitude 2^(IN_W-1).

Reset
REQ-027 rst_n low SHALL clear all stage valid bits immediately; out_valid=0, out_data=0, out_flags=0, in_ready=1 after release.
REQ-028 Reset mid-operation discards all in-flight requests; no result of them SHALL appear after release.
REQ-029 Datapath flops need not be reset; only valid bits and outputs listed in REQ-027.

Structure
REQ-030 Shared package holds rounding-mode constants, flag bit indices, recoded-zero exponent constant, and recoded-width function.
REQ-031 Leading-zero counter is one sub-module, lzc_pri, parametrised by width, purely combinational.
REQ-032 Implementation 120-400 lines; no latches; no multicycle paths.

Verification (IN_W=64, EXP_W=8, SIG_W=24)
REQ-033 Signed 1, rm=0 -> 3 cycles later out_data=33'h080000000, flags=0.
REQ-034 Signed -1 (all ones) -> out_data=33'h180000000; unsigned 0 -> out_data=0, flags=0.
REQ-035 Unsigned 2^24+1: rm=0 -> 33'h08C000000, inexact=1; rm=3 -> 33'h08C000001, inexact=1.
REQ-036 Unsigned 64'hFFFFFFFFFFFFFFFF, rm=0 -> carry-out, out_data=33'h0A0000000, inexact=1; rm=1 -> 33'h09FFFFFFF.
REQ-037 Back-to-back 6 requests with out_ready low 5 cycles -> in_ready low after 3 accepted, out_data held stable, all 6 delivered in order.
REQ-038 Assert rst_n low with 3 in flight -> out_valid=0 immediately; no stale result after release; next request completes in 3 cycles.
